// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared state encoding, ADC config constants and helpers
// for the ADC scan controller and its SPI shift engine.
package adc_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } scan_state_e;

   localparam logic CFG_SINGLE = 1'b1;
   localparam logic CFG_UNI    = 1'b1;

   localparam int ADC_BITS = 12;
   localparam int CFG_BITS = 6;

   // {S/D, O/S, S1, S0, UNI, SLP}; the ADC wants the address bits
   // in odd-sign, select-1, select-0 order.
   function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
      return {CFG_SINGLE, ch[0], ch[2], ch[1], CFG_UNI, 1'b0};
   endfunction

   // Dot: 1<<idx.  Bar: (2<<idx)-1, done in 9 bits so idx=7 gives 8'hFF.
   function automatic logic [7:0] led_encode(input logic [2:0] idx,
                                             input logic       bar);
      logic [8:0] one_hot;
      one_hot = 9'd1 << idx;
      if (bar) return 8'((one_hot << 1) - 9'd1);
      return one_hot[7:0];
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: one 12-bit SPI frame (SCLK divider, TX/RX shifters).
// Ports: clk/reset; go (start pulse), cfg (6-bit word, MSB first);
//        sdo (MISO in), sdi/scl (MOSI/SCLK out); done (1-cycle pulse on
//        the last cycle of the frame), rx (received word).
module spi_shift_engine
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [5:0]        cfg,
   input  logic              sdo,
   output logic              sdi,
   output logic              scl,
   output logic              done,
   output logic [DATA_W-1:0] rx
);
   import adc_scan_pkg::*;

   localparam int         HW        = $clog2(CLK_DIV + 1);
   localparam logic [4:0] LAST_HALF = 5'(2 * ADC_BITS - 1);

   logic          active;
   logic [HW-1:0] half_cnt;
   logic [4:0]    half_idx;
   logic [4:0]    tx;
   logic          half_end;

   assign half_end = (half_cnt == HW'(CLK_DIV - 1));
   assign done     = active && half_end && (half_idx == LAST_HALF);

   // Even halves are SCLK high, odd halves low. MISO is captured as
   // SCLK is driven high; the go edge counts as the first rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         scl      <= 1'b0;
         sdi      <= 1'b0;
         tx       <= '0;
         half_cnt <= '0;
         half_idx <= '0;
         rx       <= '0;
      end else if (go && !active) begin
         active   <= 1'b1;
         scl      <= 1'b1;
         sdi      <= cfg[5];
         tx       <= cfg[4:0];
         half_cnt <= '0;
         half_idx <= '0;
         rx       <= {rx[DATA_W-2:0], sdo};
      end else if (active) begin
         if (!half_end) begin
            half_cnt <= half_cnt + 1'b1;
         end else begin
            half_cnt <= '0;
            half_idx <= half_idx + 5'd1;
            if (half_idx == LAST_HALF) begin
               active <= 1'b0;
               scl    <= 1'b0;
            end else if (scl) begin
               scl <= 1'b0;
               sdi <= tx[4];
               tx  <= {tx[3:0], 1'b0};
            end else begin
               scl <= 1'b1;
               rx  <= {rx[DATA_W-2:0], sdo};
            end
         end
      end
   end

endmodule

// File: rtl/adc_scan_controller.sv
// adc_scan_controller: scans ADC channels 0..NUM_CH-1 over SPI, keeps the
// latest result per channel and drives an 8-LED level meter.
// Ports: ref_clk/reset; start, continuous (scan control); led_ch, bar_mode
//        (meter select); spi_sdo/spi_sdi/spi_scl/CONVST (ADC pins);
//        data, ch_valid, scan_done, busy (results/status); LEDs.
module adc_scan_controller
#(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 12,
   parameter int CLK_DIV = 2,
   parameter int T_CONV  = 80,
   parameter int T_GAP   = 4
) (
   input  logic                     ref_clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     continuous,
   input  logic [2:0]               led_ch,
   input  logic                     bar_mode,
   input  logic                     spi_sdo,
   output logic                     spi_sdi,
   output logic                     spi_scl,
   output logic                     CONVST,
   output logic [NUM_CH*DATA_W-1:0] data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic                     scan_done,
   output logic                     busy,
   output logic [7:0]               LEDs
);
   import adc_scan_pkg::*;

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] CONV  = ST_CONV;
   localparam logic [1:0] SHIFT = ST_SHIFT;
   localparam logic [1:0] GAP   = ST_GAP;

   localparam int CMAX = (T_CONV > T_GAP) ? T_CONV : T_GAP;
   localparam int CW   = $clog2(CMAX + 1);

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [3:0]        f;
   logic [DATA_W-1:0] res [NUM_CH];
   logic [2:0]        addr;
   logic [5:0]        cfg;
   logic              go;
   logic              done;
   logic [DATA_W-1:0] rx;
   logic              conv_end;
   logic              gap_end;
   logic              last_frame;
   logic [2:0]        led_idx;
   logic              led_ok;

   assign conv_end   = (state == CONV) && (cnt == CW'(T_CONV - 1));
   assign gap_end    = (state == GAP) && (cnt == CW'(T_GAP - 1));
   assign last_frame = (f == 4'(NUM_CH));
   // The extra trailing frame only flushes the pipeline; address 0.
   assign addr       = (f < 4'(NUM_CH)) ? f[2:0] : 3'd0;
   assign cfg        = cfg_word(addr);
   assign go         = conv_end;
   assign busy       = (state != IDLE);

   spi_shift_engine #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (DATA_W)
   ) u_spi (
      .clk   (ref_clk),
      .reset (reset),
      .go    (go),
      .cfg   (cfg),
      .sdo   (spi_sdo),
      .sdi   (spi_sdi),
      .scl   (spi_scl),
      .done  (done),
      .rx    (rx)
   );

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         f         <= '0;
         CONVST    <= 1'b0;
         ch_valid  <= '0;
         scan_done <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) res[k] <= '0;
      end else begin
         ch_valid  <= '0;
         scan_done <= ch_valid[NUM_CH-1];
         unique case (state)
            IDLE: begin
               // A start coinciding with scan_done is dropped.
               if ((start && !scan_done) || continuous) begin
                  state  <= CONV;
                  cnt    <= '0;
                  f      <= '0;
                  CONVST <= 1'b1;
               end
            end
            CONV: begin
               if (conv_end) begin
                  state  <= SHIFT;
                  CONVST <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (done) begin
                  state <= GAP;
                  cnt   <= '0;
                  // Frame f carries the conversion addressed in frame f-1.
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (f == 4'(k + 1)) begin
                        res[k]      <= rx;
                        ch_valid[k] <= 1'b1;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_end) begin
                  cnt <= '0;
                  if (!last_frame) begin
                     f      <= f + 4'd1;
                     state  <= CONV;
                     CONVST <= 1'b1;
                  end else if (continuous) begin
                     f      <= '0;
                     state  <= CONV;
                     CONVST <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign data[k*DATA_W +: DATA_W] = res[k];
   end

   always_comb begin
      led_idx = 3'd0;
      led_ok  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (led_ch == 3'(k)) begin
            led_idx = res[k][DATA_W-1 -: 3];
            led_ok  = 1'b1;
         end
      end
   end

   assign LEDs = led_ok ? led_encode(led_idx, bar_mode) : 8'h00;

endmodule
